// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the fetch/dispatch front end
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int NUM_UNITS = 9;

  // Bit position of each execution unit inside unit_enable_n.
  typedef enum int unsigned {
    UNIT_LUI    = 0,
    UNIT_AUIPC  = 1,
    UNIT_JAL    = 2,
    UNIT_JALR   = 3,
    UNIT_BRANCH = 4,
    UNIT_LOAD   = 5,
    UNIT_STORE  = 6,
    UNIT_OP_IMM = 7,
    UNIT_OP     = 8
  } unit_idx_t;

  typedef enum logic [1:0] {
    TRAP_NONE       = 2'd0,
    TRAP_ILLEGAL    = 2'd1,
    TRAP_MISALIGNED = 2'd2,
    TRAP_BUS_ERR    = 2'd3
  } trap_cause_t;

  typedef enum logic [1:0] {
    FD_FETCH    = 2'd0,
    FD_DISPATCH = 2'd1,
    FD_TRAP     = 2'd2
  } fd_state_t;

endpackage

// File: rtl/opcode_decoder.sv
// rtl/opcode_decoder.sv - major opcode to one-hot execution unit match
module opcode_decoder
  import riscv_pkg::*;
(
  input  logic [6:0]           opcode_i,
  output logic [NUM_UNITS-1:0] match_o,
  output logic                 illegal_o
);

  // Full 7-bit compare, so a word whose low bits are not 2'b11 never matches.
  always_comb begin
    match_o = '0;
    case (opcode_i)
      OPC_LUI:    match_o[UNIT_LUI]    = 1'b1;
      OPC_AUIPC:  match_o[UNIT_AUIPC]  = 1'b1;
      OPC_JAL:    match_o[UNIT_JAL]    = 1'b1;
      OPC_JALR:   match_o[UNIT_JALR]   = 1'b1;
      OPC_BRANCH: match_o[UNIT_BRANCH] = 1'b1;
      OPC_LOAD:   match_o[UNIT_LOAD]   = 1'b1;
      OPC_STORE:  match_o[UNIT_STORE]  = 1'b1;
      OPC_OP_IMM: match_o[UNIT_OP_IMM] = 1'b1;
      OPC_OP:     match_o[UNIT_OP]     = 1'b1;
      default:    match_o = '0;
    endcase
    illegal_o = (match_o == '0);
  end

endmodule

// File: rtl/fetch_dispatch.sv
// rtl/fetch_dispatch.sv - single-issue fetch, decode and unit dispatch with trap halt
module fetch_dispatch
  import riscv_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_err,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] program_counter,
  output logic [8:0]      unit_enable_n,
  input  logic            exec_done,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            trap_valid,
  output logic [1:0]      trap_cause
);

  fd_state_t       state_q, state_d;
  trap_cause_t     cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            run_q;
  logic [8:0]      match;
  logic            illegal;

  opcode_decoder u_decoder (
    .opcode_i  (instr_q[6:0]),
    .match_o   (match),
    .illegal_o (illegal)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      FD_FETCH: begin
        if (run_q && imem_ack) begin
          if (imem_err) begin
            state_d = FD_TRAP;
            cause_d = TRAP_BUS_ERR;
          end else begin
            instr_d = imem_rdata;
            state_d = FD_DISPATCH;
          end
        end
      end
      FD_DISPATCH: begin
        if (illegal) begin
          state_d = FD_TRAP;
          cause_d = TRAP_ILLEGAL;
        end else if (exec_done) begin
          if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            state_d = FD_TRAP;
            cause_d = TRAP_MISALIGNED;
          end else begin
            pc_d    = redirect_valid ? redirect_target : pc_q + XLEN'(4);
            state_d = FD_FETCH;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // run_q holds the request off until the first edge after reset release,
  // which also masks any acknowledge left over from an aborted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FD_FETCH;
      cause_q <= TRAP_NONE;
      pc_q    <= RESET_VECTOR;
      instr_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      run_q   <= 1'b1;
    end
  end

  assign imem_req        = run_q && (state_q == FD_FETCH);
  assign imem_addr       = pc_q;
  assign instruction     = instr_q;
  assign program_counter = pc_q;
  assign unit_enable_n   = (state_q == FD_DISPATCH) ? ~match : 9'h1FF;
  assign trap_valid      = (state_q == FD_TRAP);
  assign trap_cause      = cause_q;

endmodule

// File: tb/tb_fetch_dispatch.sv
// tb/tb_fetch_dispatch.sv - scoreboard bench for fetch_dispatch against a reference model
module tb_fetch_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_err = 1'b0;
  logic [31:0] instruction;
  logic [31:0] program_counter;
  logic [8:0]  unit_enable_n;
  logic        exec_done = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap_valid;
  logic [1:0]  trap_cause;

  always #5 clk = ~clk;

  fetch_dispatch #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .imem_err        (imem_err),
    .instruction     (instruction),
    .program_counter (program_counter),
    .unit_enable_n   (unit_enable_n),
    .exec_done       (exec_done),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_cause      (trap_cause)
  );

  typedef struct {
    logic [8:0]  en;
    logic [31:0] pc;
    logic [31:0] ins;
  } disp_t;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] pc;
  } trap_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_addr[$];
  disp_t       exp_disp[$];
  trap_t       exp_trap[$];

  // Unit order: lui, auipc, jal, jalr, branch, load, store, op_imm, op.
  logic [6:0] opc_tab[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  logic [31:0] m_pc = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: observed 0x%08h, expected no such event", name, act);
  endtask

  function automatic int unit_of(input logic [6:0] opc);
    for (int i = 0; i < 9; i++)
      if (opc_tab[i] == opc) return i;
    return -1;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a fetch, dispatch or trap.
  disp_t cur_disp;
  logic  cur_ok = 1'b0;
  logic [8:0] prev_en = 9'h1FF;
  logic  prev_trap = 1'b0;

  always @(negedge clk) begin : monitor
    disp_t d;
    logic  ok;
    trap_t t;
    if (!rst_n) begin
      check("reset_imem_req", 32'(imem_req), 32'd0);
      check("reset_enables", 32'(unit_enable_n), 32'h1FF);
      prev_en   <= 9'h1FF;
      prev_trap <= 1'b0;
      cur_ok    <= 1'b0;
    end else begin
      if (imem_req && imem_ack) begin
        if (exp_addr.size() == 0) fail_event("unexpected_fetch", imem_addr);
        else check("fetch_addr", imem_addr, exp_addr.pop_front());
      end
      if (imem_req) check("enables_idle_in_fetch", 32'(unit_enable_n), 32'h1FF);
      if (unit_enable_n != 9'h1FF) begin
        d  = cur_disp;
        ok = cur_ok;
        if (prev_en == 9'h1FF) begin
          if (exp_disp.size() == 0) begin
            fail_event("unexpected_enable", 32'(unit_enable_n));
            ok = 1'b0;
          end else begin
            d  = exp_disp.pop_front();
            ok = 1'b1;
          end
        end
        if (ok) begin
          check("unit_enable_n", 32'(unit_enable_n), 32'(d.en));
          check("dispatch_pc", program_counter, d.pc);
          check("dispatch_instr", instruction, d.ins);
        end
        cur_disp <= d;
        cur_ok   <= ok;
      end
      if (trap_valid && !prev_trap) begin
        if (exp_trap.size() == 0) fail_event("unexpected_trap", 32'(trap_cause));
        else begin
          t = exp_trap.pop_front();
          check("trap_cause", 32'(trap_cause), 32'(t.cause));
          check("trap_pc", program_counter, t.pc);
        end
      end
      if (trap_valid) begin
        check("trap_imem_req", 32'(imem_req), 32'd0);
        check("trap_enables", 32'(unit_enable_n), 32'h1FF);
      end
      prev_en   <= unit_enable_n;
      prev_trap <= trap_valid;
    end
  end

  task automatic wait_req(output bit ok);
    int t = 0;
    while (!imem_req && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    ok = imem_req;
    if (!ok) fail_event("imem_req_timeout", 32'(t));
  endtask

  // Fetch with random exec noise before the ack; it must be ignored in FETCH.
  task automatic do_fetch(input logic [31:0] word, input bit err, input int delay, output bit ok);
    wait_req(ok);
    if (!ok) return;
    repeat (delay) begin
      exec_done       = 1'($urandom_range(0, 1));
      redirect_valid  = 1'($urandom_range(0, 1));
      redirect_target = $urandom;
      @(posedge clk); #1;
    end
    exec_done      = 1'b0;
    redirect_valid = 1'b0;
    imem_ack       = 1'b1;
    imem_rdata     = word;
    imem_err       = err;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_err   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic run_instr(input logic [31:0] word, input int delay, input int hold,
                           input bit rv, input logic [31:0] target);
    int    idx;
    bit    ok;
    disp_t d;
    trap_t t;
    idx = unit_of(word[6:0]);
    exp_addr.push_back(m_pc);
    if (idx < 0) begin
      t.cause = 2'd1;
      t.pc    = m_pc;
      exp_trap.push_back(t);
    end else begin
      d.en  = ~(9'h1 << idx);
      d.pc  = m_pc;
      d.ins = word;
      exp_disp.push_back(d);
    end
    do_fetch(word, 1'b0, delay, ok);
    if (!ok) return;
    if (idx < 0) begin
      repeat (4) begin @(posedge clk); #1; end
      return;
    end
    repeat (hold) begin
      redirect_valid  = 1'($urandom_range(0, 1));
      redirect_target = $urandom;
      @(posedge clk); #1;
    end
    exec_done       = 1'b1;
    redirect_valid  = rv;
    redirect_target = target;
    if (rv && target[1:0] != 2'b00) begin
      t.cause = 2'd2;
      t.pc    = m_pc;
      exp_trap.push_back(t);
    end else begin
      m_pc = rv ? target : m_pc + 32'd4;
    end
    @(posedge clk); #1;
    exec_done      = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_req_immediate", 32'(imem_req), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("reset_pc", program_counter, 32'h0);
    check("reset_instr", instruction, 32'h0);
    check("reset_trap_valid", 32'(trap_valid), 32'd0);
    check("reset_trap_cause", 32'(trap_cause), 32'd0);
    rst_n = 1'b1;
    #1;
    check("no_req_before_first_edge", 32'(imem_req), 32'd0);
    m_pc = 32'h0;
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    r = $urandom;
    return {r[31:7], opc_tab[$urandom_range(0, 8)]};
  endfunction

  task automatic random_run(input int n);
    bit          rv;
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      rv = ($urandom_range(0, 3) == 0);
      r  = $urandom;
      run_instr(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 3), rv,
                rv ? {r[31:2], 2'b00} : r);
    end
  endtask

  initial begin : stimulus
    bit    ok;
    trap_t t;
    #1;
    @(posedge clk); #1;
    do_reset();

    run_instr(32'h0000_1517, 0, 3, 1'b0, 32'h0000_0003);
    run_instr(rand_legal(), 1, 0, 1'b1, 32'h0000_0100);
    run_instr(32'h0000_006F, 0, 1, 1'b1, 32'h0000_0200);
    random_run(40);

    // pc + 4 wraps from the top of the address space.
    run_instr(rand_legal(), 0, 0, 1'b1, 32'hFFFF_FFFC);
    run_instr(32'h00B5_0533, 0, 0, 1'b0, 32'h0);
    run_instr(rand_legal(), 0, 2, 1'b1, 32'h0000_0100);
    run_instr(32'h0000_006F, 0, 0, 1'b1, 32'h0000_0202);
    repeat (4) begin @(posedge clk); #1; end
    check("misaligned_pc_held", program_counter, 32'h0000_0100);

    do_reset();
    run_instr(32'h0000_000B, 0, 0, 1'b0, 32'h0);
    check("illegal_req_low", 32'(imem_req), 32'd0);

    do_reset();
    run_instr(rand_legal(), 0, 0, 1'b1, 32'h0000_0040);
    exp_addr.push_back(m_pc);
    t.cause = 2'd3;
    t.pc    = m_pc;
    exp_trap.push_back(t);
    do_fetch($urandom, 1'b1, 1, ok);
    repeat (3) begin @(posedge clk); #1; end
    check("bus_err_pc", program_counter, 32'h0000_0040);

    do_reset();
    random_run(5);
    wait_req(ok);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_000B;
    rst_n      = 1'b0;
    #1;
    check("req_drop_on_reset", 32'(imem_req), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    m_pc  = 32'h0;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    check("late_ack_ignored_instr", instruction, 32'h0);
    check("late_ack_ignored_addr", imem_addr, 32'h0);
    random_run(20);

    repeat (3) begin @(posedge clk); #1; end
    check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
    check("disp_queue_drained", 32'(exp_disp.size()), 32'd0);
    check("trap_queue_drained", 32'(exp_trap.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
